// File: rtl/aes_round_ctrl.sv
// AES round sequencer: INIT (AddRoundKey), Nr-1 middle rounds, FINAL; optional abort via `AES_CTRL_ABORT_EN.
// Latency: accept at cycle 0, state_we in cycles 1..Nr+1, out_valid from cycle Nr+2.
// Backpressure: key_ready low stalls the round walk; out_valid holds until out_ready; one block at a time.
module aes_round_ctrl #(
    parameter int Nr = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_ready,
    input  logic          in_valid,
    input  logic          in_mode,
    output logic          in_ready,
    output logic [1:0]    stage_sel,
    output logic          state_we,
    output logic [RW-1:0] round_idx,
    output logic [RW-1:0] key_sel,
    output logic          mode,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);

    if (!(Nr == 10 || Nr == 12 || Nr == 14)) begin : g_bad_nr
        $error("aes_round_ctrl: Nr must be 10, 12 or 14");
    end
    if ((2 ** RW) <= Nr) begin : g_bad_rw
        $error("aes_round_ctrl: RW too narrow for Nr");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [RW-1:0] NR_W     = RW'(Nr);
    localparam logic [RW-1:0] LAST_MID = RW'(Nr - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic          mode_q, mode_d;
`ifdef AES_CTRL_ABORT_EN
    logic          aborted_q, aborted_d;
`endif

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        mode_d    = mode_q;
        stage_sel = 2'd0;
        state_we  = 1'b0;
        out_valid = 1'b0;
`ifdef AES_CTRL_ABORT_EN
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && key_ready) begin
                    mode_d  = in_mode;
                    round_d = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                state_we = key_ready;
                if (key_ready) begin
                    round_d = RW'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                stage_sel = 2'd1;
                state_we  = key_ready;
                if (key_ready) begin
                    round_d = round_q + RW'(1);
                    if (round_q == LAST_MID) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                stage_sel = 2'd2;
                state_we  = key_ready;
                if (key_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    round_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
`ifdef AES_CTRL_ABORT_EN
        // Abort overrides stall and the output handshake.
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            round_d   = '0;
            aborted_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            round_q   <= '0;
            mode_q    <= 1'b0;
`ifdef AES_CTRL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            mode_q    <= mode_d;
`ifdef AES_CTRL_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Decrypt walks the key schedule backwards.
    always_comb begin
        key_sel = '0;
        if (state_q == INIT || state_q == ROUND || state_q == FINAL) begin
            key_sel = mode_q ? (NR_W - round_q) : round_q;
        end
    end

    assign in_ready  = (state_q == IDLE) && key_ready;
    assign busy      = (state_q != IDLE);
    assign round_idx = round_q;
    assign mode      = mode_q;
`ifdef AES_CTRL_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequencer for the iterative AES round datapath (initial AddRoundKey, Nr-1 middle rounds, final round without MixColumns).
- Accepts one 128-bit block per transaction via valid/ready and tracks the round count.
- Drives the datapath's state-register write enable, stage select and round-key index; holds the result until the consumer takes it.
- Serves both encrypt and decrypt datapaths via a per-block mode bit.

Parameters:
- Nr, 10, number of rounds; legal values 10, 12, 14. Any other value is a configuration error.
- RW, 4, width of round_idx and key_sel; must satisfy 2^RW > Nr.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- key_ready  input  1  expanded key schedule is valid.
- in_valid  input  1  input block valid.
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
- in_ready  output  1  controller can accept a block.
- stage_sel  output  2  0 = initial AddRoundKey, 1 = middle round, 2 = final round, 3 = unused (never driven).
- state_we  output  1  datapath state register load enable.
- round_idx  output  RW  current round number, 0..Nr.
- key_sel  output  RW  round-key index into the word bus.
- mode  output  1  latched mode of the block in flight.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  datapath output holds the finished block.
- out_ready  input  1  consumer accepts the block.

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-operation:
  - state goes to IDLE.
  - All outputs go to 0, except in_ready, which follows key_ready.
  - The block in flight is discarded.
- States: IDLE, INIT, ROUND, FINAL, DONE.
- Combinational outputs:
  - in_ready = (state==IDLE) && key_ready.
  - busy = (state!=IDLE).
- IDLE:
  - Accept when in_valid && in_ready; latch mode <= in_mode; round_idx <= 0; go to INIT.
- INIT:
  - stage_sel=0, round_idx=0, state_we=key_ready.
  - If key_ready: round_idx <= 1; go to ROUND.
- ROUND:
  - stage_sel=1, state_we=key_ready.
  - If key_ready: increment round_idx. When round_idx==Nr-1, go to FINAL (round_idx becomes Nr).
- FINAL:
  - stage_sel=2, round_idx=Nr, state_we=key_ready.
  - If key_ready: go to DONE.
- DONE:
  - out_valid=1, state_we=0.
  - Hold until out_ready; then go to IDLE.
  - A new block can be accepted no earlier than the cycle after the handshake; there is no overlap.
- Key index:
  - key_sel = round_idx when mode=0.
  - key_sel = Nr - round_idx when mode=1.
  - key_sel is 0 in IDLE and DONE.
- Stall: key_ready low in INIT, ROUND or FINAL freezes state and round_idx and forces state_we=0. Operation resumes on the cycle key_ready returns high.
- Latency, with no stalls:
  - Accept edge at cycle 0.
  - state_we is high in cycles 1..Nr+1 (Nr+1 writes).
  - out_valid rises at cycle Nr+2; for Nr=10 that is cycle 12.
- Stage outputs (stage_sel, state_we) are undriven/0 outside INIT, ROUND and FINAL.
- in_valid while busy is ignored; no block is queued.
- in_mode changes after accept have no effect.
- rst wins over every other input in the same cycle.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in INIT, ROUND, FINAL or DONE sends the controller to IDLE on the next edge and clears out_valid and round_idx.
  - aborted pulses high for exactly one cycle (the cycle after the abort edge).
  - abort has priority over stall and over out_ready. abort in IDLE is ignored and does not pulse aborted.
  - rst has priority over abort.
- Undefined: neither port exists and the behaviour is exactly as above.

Test Plan:
- Nr=10, key_ready=1, in_mode=0, accept at cycle 0 -> state_we high cycles 1-11; stage_sel 0,1x9,2; key_sel 0..10; out_valid at cycle 12.
- Same with in_mode=1 -> key_sel sequence 10,9,...,0; identical timing.
- key_ready dropped for 3 cycles during round 5 -> state_we=0 for those 3 cycles, round_idx holds 5, out_valid at cycle 15.
- out_ready held low 4 cycles in DONE -> out_valid stays 1, in_ready=0; IDLE after the handshake; next accept is possible one cycle later.
- rst asserted at round 7 -> next cycle all outputs 0, in_ready=key_ready; a fresh block completes with the normal latency.
- Nr=14 build with AES_CTRL_ABORT_EN; abort at round 3 -> IDLE next edge, aborted high one cycle, out_valid never asserts; Nr=14 run without abort -> out_valid at cycle 16.
